// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer; i_io_lcd {[31] on,[9] strobe,[8] rs,[7:0] data} -> o_lcd_{on,en,rs,rw,data}, status o_busy/o_init_done/o_drop
module lcd_ctrl #(
  parameter int PWRUP_CYC    = 2000000,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 25,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_drop
);
  localparam int M0 = PWRUP_CYC > CLR_WAIT_CYC ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int M1 = CMD_WAIT_CYC > EN_CYC ? CMD_WAIT_CYC : EN_CYC;
  localparam int M2 = SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC;
  localparam int M3 = M1 > M2 ? M1 : M2;
  localparam int MAXC = M0 > M3 ? M0 : M3;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
  state_t state;
  logic [CW-1:0] cnt, lim;
  logic [1:0] idx;
  logic [8:0] pend;
  logic [7:0] nxt_init;
  logic pend_v, strb_q, req, tdone, wait_end, init_next, rel, start_pend, start_req;
  logic store, drop, to_idle, nxt_pv, unused_bits;
  assign unused_bits = ^i_io_lcd[30:10];
  assign req = i_io_lcd[9] & ~strb_q;
  assign lim = state == PWRUP ? CW'(PWRUP_CYC) :
               state == SETUP ? CW'(SETUP_CYC) :
               state == PULSE ? CW'(EN_CYC) :
               state == HOLD  ? CW'(HOLD_CYC) :
               (!o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02)) ? CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);
  assign tdone = cnt == lim - 1'b1;
  assign wait_end = state == WAIT && tdone;
  assign init_next = wait_end && idx != 2'd3;
  assign rel = wait_end && idx == 2'd3;
  assign start_pend = rel && pend_v;
  assign start_req = req && (state == IDLE || (rel && !pend_v));
  assign store = req && !start_req && (!pend_v || start_pend);
  assign drop = req && !start_req && pend_v && !start_pend;
  assign nxt_pv = store || (pend_v && !start_pend);
  assign to_idle = !req && (state == IDLE || (rel && !pend_v));
  assign nxt_init = idx == 2'd0 ? 8'h0C : idx == 2'd1 ? 8'h01 : 8'h06;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= PWRUP;
      cnt <= '0;
      idx <= 2'd0;
      pend <= 9'd0;
      pend_v <= 1'b0;
      strb_q <= 1'b0;
      o_lcd_on <= 1'b0;
      o_lcd_en <= 1'b0;
      o_lcd_rs <= 1'b0;
      o_lcd_rw <= 1'b0;
      o_lcd_data <= 8'h00;
      o_busy <= 1'b1;
      o_init_done <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      strb_q <= i_io_lcd[9];
      o_lcd_on <= i_io_lcd[31];
      o_lcd_rw <= 1'b0;
      o_busy <= !to_idle || nxt_pv;
      pend_v <= nxt_pv;
      if (store) pend <= i_io_lcd[8:0];
      if (drop) o_drop <= 1'b1;
      if (rel) o_init_done <= 1'b1;
      cnt <= (state == IDLE || tdone) ? '0 : cnt + 1'b1;
      case (state)
        PWRUP: if (tdone) begin
          state <= SETUP;
          {o_lcd_rs, o_lcd_data} <= 9'h038;
        end
        SETUP: if (tdone) begin
          state <= PULSE;
          o_lcd_en <= 1'b1;
        end
        PULSE: if (tdone) begin
          state <= HOLD;
          o_lcd_en <= 1'b0;
        end
        HOLD: if (tdone) state <= WAIT;
        default: if (init_next) begin
          state <= SETUP;
          idx <= idx + 1'b1;
          {o_lcd_rs, o_lcd_data} <= {1'b0, nxt_init};
        end else if (start_pend || start_req) begin
          state <= SETUP;
          {o_lcd_rs, o_lcd_data} <= pend_v ? pend : i_io_lcd[8:0];
        end else if (wait_end) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: transaction-schedule reference model checking lcd_ctrl cycle by cycle
module tb_lcd_ctrl;
  localparam int P_PW = 10, P_S = 2, P_E = 3, P_H = 2, P_CMD = 5, P_CLR = 8;
  logic clk = 1'b0;
  logic i_reset = 1'b0;
  logic [31:0] i_io_lcd = '0;
  logic o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_busy, o_init_done, o_drop;
  logic [7:0] o_lcd_data;
  int cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int st_q[$];
  logic [8:0] cmd_q[$];
  bit usr_q[$];
  logic [8:0] rises[$];
  int drop_at = -1, init_end = 0;
  bit en_q = 1'b0;
  logic [7:0] init_c [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_ctrl #(.PWRUP_CYC(P_PW), .SETUP_CYC(P_S), .EN_CYC(P_E), .HOLD_CYC(P_H),
             .CMD_WAIT_CYC(P_CMD), .CLR_WAIT_CYC(P_CLR)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_io_lcd(i_io_lcd),
    .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_data(o_lcd_data), .o_busy(o_busy), .o_init_done(o_init_done), .o_drop(o_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, want, cyc);
    end
  endtask

  function automatic int dur(input logic [8:0] c);
    return P_S + P_E + P_H + ((!c[8] && (c[7:0] == 8'h01 || c[7:0] == 8'h02)) ? P_CLR : P_CMD);
  endfunction

  function automatic int end_last();
    return st_q.size() == 0 ? 0 : st_q[$] + dur(cmd_q[$]);
  endfunction

  task automatic push(input int s, input logic [8:0] c, input bit u);
    st_q.push_back(s);
    cmd_q.push_back(c);
    usr_q.push_back(u);
  endtask

  task automatic model_reset();
    st_q.delete();
    cmd_q.delete();
    usr_q.delete();
    rises.delete();
    drop_at = -1;
    en_q = 1'b0;
  endtask

  task automatic sched_init(input int t0);
    int t;
    t = t0;
    for (int i = 0; i < 4; i++) begin
      push(t, {1'b0, init_c[i]}, 1'b0);
      t += dur({1'b0, init_c[i]});
    end
    init_end = t;
  endtask

  task automatic add_req(input int r, input logic [8:0] c);
    int e, waiting;
    e = end_last();
    waiting = 0;
    foreach (st_q[i]) if (usr_q[i] && st_q[i] > r) waiting++;
    if (e <= r) push(r, c, 1'b1);
    else if (waiting == 0) push(e, c, 1'b1);
    else if (drop_at < 0) drop_at = r;
  endtask

  task automatic tick();
    int n;
    logic ex, xin;
    logic [8:0] xc;
    @(negedge clk);
    n = cyc;
    ex = 1'b0;
    xin = 1'b0;
    xc = '0;
    foreach (st_q[i]) begin
      if (n >= st_q[i] + P_S && n < st_q[i] + P_S + P_E) ex = 1'b1;
      if (n >= st_q[i] && n < st_q[i] + P_S + P_E + P_H) begin
        xin = 1'b1;
        xc = cmd_q[i];
      end
    end
    if (o_lcd_en === 1'b1 && !en_q) rises.push_back({o_lcd_rs, o_lcd_data});
    en_q = (o_lcd_en === 1'b1);
    chk("en", o_lcd_en, ex);
    if (xin) chk("rs_data", {o_lcd_rs, o_lcd_data}, xc);
    chk("busy", o_busy, n < end_last());
    chk("init_done", o_init_done, n >= init_end);
    chk("drop", o_drop, drop_at >= 0 && n >= drop_at);
    chk("on", o_lcd_on, i_io_lcd[31]);
    chk("rw", o_lcd_rw, 0);
  endtask

  task automatic send(input logic [8:0] c, input int gap);
    i_io_lcd[9:0] = {1'b1, c};
    add_req(cyc + 1, c);
    tick();
    i_io_lcd[9] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && o_busy !== 1'b0; i++) tick();
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_en"}, o_lcd_en, 0);
    chk({tag, "_rs"}, o_lcd_rs, 0);
    chk({tag, "_rw"}, o_lcd_rw, 0);
    chk({tag, "_data"}, o_lcd_data, 0);
    chk({tag, "_on"}, o_lcd_on, 0);
    chk({tag, "_init_done"}, o_init_done, 0);
    chk({tag, "_drop"}, o_drop, 0);
    chk({tag, "_busy"}, o_busy, 1);
  endtask

  task automatic release_rst();
    i_reset = 1'b1;
    sched_init(cyc + P_PW);
  endtask

  initial begin
    int c, r, k, base;
    logic [8:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    rst_check("por");
    release_rst();
    c = cyc;
    wait_idle("init");
    chk("init_len", cyc - c, P_PW + 51);
    chk("init_done_set", o_init_done, 1);
    chk("init_pulses", rises.size(), 4);
    for (int i = 0; i < 4 && i < rises.size(); i++) chk("init_cmd", rises[i], {1'b0, init_c[i]});

    i_io_lcd = 32'h8000_0141;
    tick();
    r = cyc + 1;
    send(9'h141, 1);
    repeat (10) tick();
    chk("single_busy_hi", o_busy, 1);
    tick();
    chk("single_busy_lo", o_busy, 0);
    chk("single_len", cyc - r, 12);
    chk("single_cmd", rises[$], 9'h141);

    send(9'h148, 1);
    send(9'h149, 1);
    wait_idle("b2b");
    chk("b2b_drop", o_drop, 0);
    chk("b2b_first", rises[rises.size() - 2], 9'h148);
    chk("b2b_second", rises[$], 9'h149);

    r = cyc + 1;
    send(9'h001, 1);
    wait_idle("clr");
    chk("clr_len", cyc - r, 15);
    r = cyc + 1;
    send(9'h101, 1);
    wait_idle("rs1_01");
    chk("rs1_01_len", cyc - r, 12);
    r = cyc + 1;
    send(9'h002, 1);
    wait_idle("home");
    chk("home_len", cyc - r, 15);

    base = rises.size();
    send(9'h150, 1);
    send(9'h151, 1);
    send(9'h152, 1);
    wait_idle("three");
    chk("three_drop", o_drop, 1);
    chk("three_count", rises.size() - base, 2);
    chk("three_last", rises[$], 9'h151);
    repeat (5) tick();
    chk("drop_sticky", o_drop, 1);

    send(9'h160, 0);
    for (int i = 0; i < 50 && o_lcd_en !== 1'b1; i++) tick();
    chk("pulse_seen", o_lcd_en, 1);
    #2;
    i_reset = 1'b0;
    i_io_lcd = '0;
    #1;
    rst_check("mid");
    model_reset();
    @(negedge clk);
    release_rst();
    c = cyc;
    repeat (3) tick();
    send(9'h1AA, 1);
    wait_idle("pwrup_req");
    chk("pwrup_req_len", cyc - c, P_PW + 51 + 12);
    chk("rerun_pulses", rises.size(), 5);
    chk("rerun_first", rises[0], 9'h038);
    chk("pwrup_req_cmd", rises[$], 9'h1AA);
    chk("pwrup_req_drop", o_drop, 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      d[8] = 1'($urandom_range(0, 1));
      d[7:0] = k == 0 ? 8'h01 : k == 1 ? 8'h02 : 8'($urandom);
      i_io_lcd[31] = 1'($urandom);
      send(d, $urandom_range(1, 16));
    end
    wait_idle("rand");
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
